// File: rtl/spi_burst_scheduler_if.sv
// Signal bundle between the requesting clients, the burst scheduler and the SPI burst receiver.
// The scheduler uses the master modport; the client/receiver side uses the slave modport.
interface spi_burst_scheduler_if #(
    parameter int REQUESTERS = 4
);
    // Handshake: request[i] is a level held until done[i] or timeout_error[i] pulses.
    // grant is one-hot and held for the whole transaction. receiver_enable is a one-cycle start.
    // The receiver then holds receiver_busy for the burst.
    // Each word is flagged by a one-cycle receiver_data_valid.
    logic [REQUESTERS-1:0]    request;
    logic [16*REQUESTERS-1:0] request_burst_count;
    logic [REQUESTERS-1:0]    grant;
    logic [REQUESTERS-1:0]    done;
    logic [REQUESTERS-1:0]    timeout_error;
    logic                     busy;
    logic [15:0]              words_received;
    logic                     receiver_enable;
    logic [15:0]              receiver_burst_count;
    logic                     receiver_busy;
    logic                     receiver_data_valid;

    modport master (
        input  request, request_burst_count, receiver_busy, receiver_data_valid,
        output grant, done, timeout_error, busy, words_received,
               receiver_enable, receiver_burst_count
    );

    modport slave (
        output request, request_burst_count, receiver_busy, receiver_data_valid,
        input  grant, done, timeout_error, busy, words_received,
               receiver_enable, receiver_burst_count
    );
endinterface

// File: rtl/spi_burst_scheduler.sv
// Round-robin scheduler sharing one SPI burst receiver between several requesters,
// with burst tracking, an idle timeout and per-requester done/timeout pulses.
module spi_burst_scheduler #(
    parameter int REQUESTERS     = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clock,
    input  logic                  reset,
    spi_burst_scheduler_if.master bus,
    output logic [1:0]            state_o
);

    localparam int          IDX_W         = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_ACTIVE    = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      last_q, last_d;
    logic [IDX_W-1:0]      gidx_q, gidx_d;
    logic [REQUESTERS-1:0] grant_q, grant_d;
    logic [REQUESTERS-1:0] done_q, done_d;
    logic [REQUESTERS-1:0] tmo_err_q, tmo_err_d;
    logic                  enable_q, enable_d;
    logic [15:0]           burst_q, burst_d;
    logic [15:0]           words_q, words_d;
    logic [15:0]           tcnt_q, tcnt_d;
    logic                  err_q, err_d;

    logic                  arb_found;
    logic [IDX_W-1:0]      arb_idx;
    logic [REQUESTERS-1:0] arb_onehot;
    logic [15:0]           arb_count;
    logic [REQUESTERS-1:0] req_rot;
    int                    cand;

    // Search starts just after the last served requester, so the first hit is the fair winner.
    always_comb begin
        arb_found  = 1'b0;
        arb_idx    = '0;
        arb_onehot = '0;
        arb_count  = '0;
        req_rot    = '0;
        cand       = 0;
        for (int i = 1; i <= REQUESTERS; i++) begin
            cand    = (int'(last_q) + i) % REQUESTERS;
            req_rot = bus.request >> cand;
            if (!arb_found && req_rot[0]) begin
                arb_found  = 1'b1;
                arb_idx    = IDX_W'(cand);
                arb_onehot = {{(REQUESTERS-1){1'b0}}, 1'b1} << cand;
                arb_count  = 16'(bus.request_burst_count >> (16 * cand));
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        done_d    = '0;
        tmo_err_d = '0;
        enable_d  = 1'b0;
        burst_d   = burst_q;
        words_d   = words_q;
        tcnt_d    = tcnt_q;
        err_d     = err_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gidx_d  = arb_idx;
                    grant_d = arb_onehot;
                    burst_d = arb_count;
                    words_d = '0;
                    tcnt_d  = '0;
                    err_d   = 1'b0;
                    if (arb_count == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        enable_d = 1'b1;
                        state_d  = S_WAIT_BUSY;
                    end
                end
            end
            S_WAIT_BUSY, S_ACTIVE: begin
                tcnt_d = bus.receiver_data_valid ? 16'd0 : tcnt_q + 16'd1;
                if (state_q == S_ACTIVE && bus.receiver_data_valid && words_q != 16'hFFFF) begin
                    words_d = words_q + 16'd1;
                end
                // A burst whose busy falls is complete even if the idle count expires on that edge.
                if (state_q == S_ACTIVE && !bus.receiver_busy) begin
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (tcnt_d == TIMEOUT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (state_q == S_WAIT_BUSY && bus.receiver_busy) begin
                    state_d = S_ACTIVE;
                end
            end
            S_DONE: begin
                // The receiver cannot be aborted, so a timed-out burst drains before release.
                if (!bus.receiver_busy) begin
                    if (err_q) tmo_err_d = grant_q;
                    else       done_d    = grant_q;
                    grant_d = '0;
                    last_d  = gidx_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_q    <= IDX_W'(REQUESTERS - 1);
            gidx_q    <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            tmo_err_q <= '0;
            enable_q  <= 1'b0;
            burst_q   <= '0;
            words_q   <= '0;
            tcnt_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            tmo_err_q <= tmo_err_d;
            enable_q  <= enable_d;
            burst_q   <= burst_d;
            words_q   <= words_d;
            tcnt_q    <= tcnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.grant                = grant_q;
    assign bus.done                 = done_q;
    assign bus.timeout_error        = tmo_err_q;
    assign bus.busy                 = (state_q != S_IDLE);
    assign bus.words_received       = words_q;
    assign bus.receiver_enable      = enable_q;
    assign bus.receiver_burst_count = burst_q;
    assign state_o                  = state_q;

endmodule

// File: tb/tb_spi_burst_scheduler.sv
// Directed bench for spi_burst_scheduler: a small receiver model, an event monitor and
// a linear sequence of steps with hand-computed expectations.
module tb_spi_burst_scheduler;

    localparam int REQ = 4;
    localparam int TMO = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [1:0] state_o;

    int errors = 0;
    int checks = 0;

    spi_burst_scheduler_if #(.REQUESTERS(REQ)) bus ();

    spi_burst_scheduler #(.REQUESTERS(REQ), .TIMEOUT_CYCLES(TMO)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .state_o (state_o)
    );

    always #5 clock = ~clock;

    // Receiver model controls
    int   model_words = 0;
    int   model_gap   = 1;
    logic model_hold  = 1'b0;
    logic model_simul = 1'b0;

    // Monitor results
    int         enable_cnt = 0;
    int         done_cnt   = 0;
    int         tmo_cnt    = 0;
    int         bad_cnt    = 0;
    int         zero_run   = 0;
    logic [3:0] grant_log[$];
    int         gap_log[$];
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    function automatic logic [3:0] grant_at(input int idx);
        if (idx < grant_log.size()) return grant_log[idx];
        return 4'hF;
    endfunction

    function automatic int gap_at(input int idx);
        if (idx < gap_log.size()) return gap_log[idx];
        return -1;
    endfunction

    // Receiver: busy one cycle after the enable is seen, then words spaced by model_gap.
    initial begin
        bus.receiver_busy       = 1'b0;
        bus.receiver_data_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (bus.receiver_enable) begin
                @(negedge clock);
                bus.receiver_busy = 1'b1;
                if (model_hold) begin
                    while (model_hold) @(negedge clock);
                    bus.receiver_busy = 1'b0;
                end else begin
                    for (int k = 0; k < model_words; k++) begin
                        repeat (model_gap) @(negedge clock);
                        bus.receiver_data_valid = 1'b1;
                        if (model_simul && k == model_words - 1) bus.receiver_busy = 1'b0;
                        @(negedge clock);
                        bus.receiver_data_valid = 1'b0;
                    end
                    bus.receiver_busy = 1'b0;
                end
            end
        end
    end

    // Monitor: pulse counts, one-hot/exclusivity violations, grant order and idle gaps.
    initial begin
        forever begin
            @(negedge clock);
            if (bus.receiver_enable === 1'b1) enable_cnt++;
            if (bus.done != 4'd0) done_cnt++;
            if (bus.timeout_error != 4'd0) tmo_cnt++;
            if ((bus.done != 4'd0 && bus.timeout_error != 4'd0) || $countones(bus.done) > 1 ||
                $countones(bus.timeout_error) > 1 || $countones(bus.grant) > 1) bad_cnt++;
            if (bus.grant != 4'd0) begin
                if (zero_run > 0) begin
                    grant_log.push_back(bus.grant);
                    gap_log.push_back(zero_run);
                end
                zero_run = 0;
            end else begin
                zero_run++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int gb;
        int eb;
        int db;
        int tb0;

        reset                   = 1'b1;
        bus.request             = '0;
        bus.request_burst_count = '0;
        repeat (3) step();

        check("rst_grant", bus.grant, 4'd0);
        check("rst_done", bus.done, 4'd0);
        check("rst_tmo", bus.timeout_error, 4'd0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_words", bus.words_received, 16'd0);
        check("rst_enable", bus.receiver_enable, 1'b0);
        check("rst_burst", bus.receiver_burst_count, 16'd0);
        check("rst_state", state_o, 2'd0);
        reset = 1'b0;
        step();

        // Round robin from reset: requesters 0, 2, 3 each one word
        model_words = 1;
        model_gap   = 1;
        gb = grant_log.size();
        db = done_cnt;
        tb0 = tmo_cnt;
        bus.request_burst_count = {16'd1, 16'd1, 16'd1, 16'd1};
        bus.request = 4'b1101;
        n = 0;
        while (done_cnt - db < 4 && n < 300) begin
            step();
            n++;
        end
        bus.request = '0;
        check("rr_budget", n < 300, 1'b1);
        exp_q = {4'b0001, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 4; i++) begin
            check("rr_grant", grant_at(gb + i), exp_q.pop_front());
        end
        for (int i = 1; i < 4; i++) begin
            check("rr_gap", gap_at(gb + i), 1);
        end
        check("rr_words", bus.words_received, 16'd1);
        check("rr_tmo", tmo_cnt - tb0, 0);
        step();
        check("rr_no_extra", grant_log.size() - gb, 4);

        // Requester 1, three words
        model_words = 3;
        gb = grant_log.size();
        eb = enable_cnt;
        db = done_cnt;
        tb0 = tmo_cnt;
        bus.request_burst_count = {16'd0, 16'd0, 16'd3, 16'd0};
        bus.request = 4'b0010;
        n = 0;
        while (done_cnt == db && n < 100) begin
            step();
            n++;
        end
        check("t1_budget", n < 100, 1'b1);
        check("t1_done", bus.done, 4'b0010);
        check("t1_words", bus.words_received, 16'd3);
        check("t1_burst", bus.receiver_burst_count, 16'd3);
        check("t1_grant_off", bus.grant, 4'd0);
        check("t1_idle", bus.busy, 1'b0);
        check("t1_grant", grant_at(gb), 4'b0010);
        check("t1_enables", enable_cnt - eb, 1);
        check("t1_tmo", tmo_cnt - tb0, 0);
        bus.request = '0;
        step();
        check("t1_done_pulse", bus.done, 4'd0);

        // Requester 2, zero-length burst skips the receiver
        eb = enable_cnt;
        bus.request_burst_count = {16'd9, 16'd0, 16'd9, 16'd9};
        bus.request = 4'b0100;
        step();
        check("z_grant", bus.grant, 4'b0100);
        check("z_busy", bus.busy, 1'b1);
        check("z_state", state_o, 2'd3);
        step();
        check("z_done", bus.done, 4'b0100);
        check("z_words", bus.words_received, 16'd0);
        check("z_grant_off", bus.grant, 4'd0);
        bus.request = '0;
        step();
        check("z_done_pulse", bus.done, 4'd0);
        check("z_enables", enable_cnt - eb, 0);

        // Requester 0, five words six cycles apart; last word coincides with busy falling
        model_words = 5;
        model_gap   = 5;
        model_simul = 1'b1;
        db = done_cnt;
        tb0 = tmo_cnt;
        bus.request_burst_count = {16'd0, 16'd0, 16'd0, 16'd5};
        bus.request = 4'b0001;
        n = 0;
        while (done_cnt == db && tmo_cnt == tb0 && n < 200) begin
            step();
            n++;
        end
        check("g_budget", n < 200, 1'b1);
        check("g_done", bus.done, 4'b0001);
        check("g_words", bus.words_received, 16'd5);
        check("g_tmo", tmo_cnt - tb0, 0);
        bus.request = '0;
        model_simul = 1'b0;
        step();

        // Requester 3, receiver holds busy with no words: timeout after 8 cycles, drains later
        model_hold = 1'b1;
        db = done_cnt;
        tb0 = tmo_cnt;
        bus.request_burst_count = {16'd4, 16'd0, 16'd0, 16'd0};
        bus.request = 4'b1000;
        step();
        check("to_grant", bus.grant, 4'b1000);
        n = 0;
        while (state_o != 2'd3 && n < 40) begin
            step();
            n++;
        end
        check("to_fire_cycle", n, 8);
        repeat (4) step();
        check("to_drain_tmo", bus.timeout_error, 4'd0);
        check("to_drain_done", bus.done, 4'd0);
        check("to_drain_grant", bus.grant, 4'b1000);
        model_hold = 1'b0;
        n = 0;
        while (tmo_cnt == tb0 && n < 20) begin
            step();
            n++;
        end
        check("to_budget", n < 20, 1'b1);
        check("to_error", bus.timeout_error, 4'b1000);
        check("to_done", done_cnt - db, 0);
        check("to_grant_off", bus.grant, 4'd0);
        bus.request = '0;
        step();
        check("to_pulse", bus.timeout_error, 4'd0);

        // Reset in the middle of a burst after two words
        model_words = 10;
        model_gap   = 1;
        bus.request_burst_count = {16'd0, 16'd0, 16'd0, 16'd10};
        bus.request = 4'b0001;
        n = 0;
        while (bus.words_received != 16'd2 && n < 50) begin
            step();
            n++;
        end
        check("rs_budget", n < 50, 1'b1);
        check("rs_active", state_o, 2'd2);
        db = done_cnt;
        tb0 = tmo_cnt;
        reset = 1'b1;
        bus.request = '0;
        step();
        check("rs_grant", bus.grant, 4'd0);
        check("rs_busy", bus.busy, 1'b0);
        check("rs_words", bus.words_received, 16'd0);
        check("rs_enable", bus.receiver_enable, 1'b0);
        check("rs_burst", bus.receiver_burst_count, 16'd0);
        reset = 1'b0;
        n = 0;
        while (bus.receiver_busy && n < 50) begin
            step();
            n++;
        end
        repeat (3) step();
        check("rs_no_done", done_cnt - db, 0);
        check("rs_no_tmo", tmo_cnt - tb0, 0);
        check("rs_state", state_o, 2'd0);

        check("onehot_exclusive", bad_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
